platform_onchip_memory_pipe: RTL and testbench

PLATFORM_ONCHIP_MEMORY_PIPE -- requirements
Module: platform_onchip_memory_pipe

---
 rtl/platform_onchip_memory_pipe_if.sv | 26 ++
 rtl/platform_onchip_memory_pipe.sv | 94 +++++++++
 tb/tb_platform_onchip_memory_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/platform_onchip_memory_pipe_if.sv
// Bus bundle for the on-chip memory: request, write payload and read return.
interface platform_onchip_memory_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    rangeerr;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid, rangeerr
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    output waitrequest, readdata, readdatavalid, rangeerr
  );
endinterface

// File: rtl/platform_onchip_memory_pipe.sv
// Single-port on-chip memory with byte-lane writes and a fixed-latency read
// pipeline. The pipeline advances only on accepted cycles, so a stall freezes
// every register including the read return.
module platform_onchip_memory_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int DEPTH        = 32768,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reset_req,
  input  logic clken,
  platform_onchip_memory_pipe_if.slave bus
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  // Memory array carries no reset: contents survive reset_n and reset_req.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [DATA_WIDTH-1:0]   data_pipe_reg [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_pipe_reg;
  logic                    rangeerr_reg;

  logic                    accept;
  logic                    in_range;
  logic                    do_write;
  logic                    do_read;
  logic [IDX_W-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign bus.waitrequest = ~clken | reset_req;
  assign accept          = bus.chipselect & ~bus.waitrequest;
  // Full-width compare so addresses beyond DEPTH never alias onto real words.
  assign in_range        = ({1'b0, bus.address} < DEPTH_LIMIT);
  assign mem_idx         = bus.address[IDX_W-1:0];
  assign do_write        = accept & bus.write & in_range;
  // A simultaneous read and write is treated as a write only.
  assign do_read         = accept & bus.read & ~bus.write;

  // Word fetched at acceptance; zero for out-of-range reads and non-reads so
  // the return path carries zero whenever it is not valid.
  always_comb begin
    rd_word = '0;
    if (do_read && in_range) begin
      rd_word = mem[mem_idx];
    end
  end

  // Byte-lane write into the array.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.byteenable[i]) begin
          mem[mem_idx][i*8 +: 8] <= bus.writedata[i*8 +: 8];
        end
      end
    end
  end

  // Read return shift register: stage 0 captures, later stages delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_pipe_reg <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        data_pipe_reg[s] <= '0;
      end
    end else if (accept) begin
      valid_pipe_reg[0] <= do_read;
      data_pipe_reg[0]  <= rd_word;
      for (int s = 1; s < READ_LATENCY; s++) begin
        valid_pipe_reg[s] <= valid_pipe_reg[s-1];
        data_pipe_reg[s]  <= data_pipe_reg[s-1];
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rangeerr_reg <= 1'b0;
    end else if (accept && (bus.read || bus.write) && !in_range) begin
      rangeerr_reg <= 1'b1;
    end
  end

  assign bus.readdatavalid = valid_pipe_reg[READ_LATENCY-1];
  assign bus.readdata      = data_pipe_reg[READ_LATENCY-1];
  assign bus.rangeerr      = rangeerr_reg;

endmodule

// File: tb/tb_platform_onchip_memory_pipe.sv
// Bench: two instances (read latency 1 and 2, DEPTH=1000) driven with the same
// stimulus and checked every cycle against a queue-based model of accepted
// operations, plus literal checks of the worked examples.
module tb_platform_onchip_memory_pipe;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, reset_req, clken, cs, rd, wr;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [31:0]   wd;

  platform_onchip_memory_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  platform_onchip_memory_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  assign bus1.chipselect = cs;   assign bus2.chipselect = cs;
  assign bus1.read       = rd;   assign bus2.read       = rd;
  assign bus1.write      = wr;   assign bus2.write      = wr;
  assign bus1.address    = addr; assign bus2.address    = addr;
  assign bus1.byteenable = be;   assign bus2.byteenable = be;
  assign bus1.writedata  = wd;   assign bus2.writedata  = wd;

  platform_onchip_memory_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .clken(clken), .bus(bus1));
  platform_onchip_memory_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .clken(clken), .bus(bus2));

  // One entry per accepted cycle: what that cycle should eventually return.
  typedef struct packed {
    logic        v;
    logic [3:0]  km;   // which bytes of d are known
    logic [31:0] d;
  } res_t;

  res_t        mq[$];
  logic [31:0] mmem   [DEPTH];
  logic [3:0]  mknown [DEPTH];
  bit          m_rerr;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] expand(input logic [3:0] km);
    return {{8{km[3]}}, {8{km[2]}}, {8{km[1]}}, {8{km[0]}}};
  endfunction

  // Output after the latest accepted edge is the result of the op accepted
  // lat accepts ago; nothing before the last reset_n counts.
  function automatic res_t exp_out(input int lat);
    res_t r;
    r = '0;
    r.km = 4'hF;
    if (mq.size() >= lat) r = mq[mq.size() - lat];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp,
                     input logic [31:0] mask);
    total++;
    if ((got & mask) !== (exp & mask)) begin
      bad++;
      $display("FAIL %s: got %h want %h (mask %h)", name, got, exp, mask);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk(name, got, exp, 32'hFFFF_FFFF);
  endtask

  // Apply the rules of one rising edge to the model, using current inputs.
  task automatic model_step();
    res_t r;
    bit   inr;
    if (!reset_n) begin
      mq.delete();
      m_rerr = 1'b0;
    end else if (cs && clken && !reset_req) begin
      inr  = (int'(addr) < DEPTH);
      r    = '0;
      r.km = 4'hF;
      r.v  = rd && !wr;
      if ((rd || wr) && !inr) m_rerr = 1'b1;
      if (r.v && inr) begin
        r.d  = mmem[addr];
        r.km = mknown[addr];
      end
      if (wr && inr) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mmem[addr][i*8 +: 8] = wd[i*8 +: 8];
            mknown[addr][i] = 1'b1;
          end
        end
      end
      mq.push_back(r);
      if (mq.size() > 4) void'(mq.pop_front());
    end
  endtask

  task automatic compare_all();
    res_t e1, e2;
    e1 = exp_out(1);
    e2 = exp_out(2);
    chk("waitrequest1", 32'(bus1.waitrequest), 32'(~clken | reset_req), 32'h1);
    chk("waitrequest2", 32'(bus2.waitrequest), 32'(~clken | reset_req), 32'h1);
    chk("readdatavalid1", 32'(bus1.readdatavalid), 32'(e1.v), 32'h1);
    chk("readdatavalid2", 32'(bus2.readdatavalid), 32'(e2.v), 32'h1);
    chk("readdata1", bus1.readdata, e1.d, expand(e1.km));
    chk("readdata2", bus2.readdata, e2.d, expand(e2.km));
    chk("rangeerr1", 32'(bus1.rangeerr), 32'(m_rerr), 32'h1);
    chk("rangeerr2", 32'(bus2.rangeerr), 32'(m_rerr), 32'h1);
  endtask

  // Drive one cycle of inputs (called at a falling edge), clock it, check.
  task automatic op(input bit c, input bit r, input bit w, input int a,
                    input logic [3:0] b, input logic [31:0] d);
    cs = c; rd = r; wr = w; addr = AW'(a); be = b; wd = d;
    $display("txn cs=%0d rd=%0d wr=%0d addr=%0d be=%h wd=%h clken=%0d rreq=%0d rst_n=%0d",
             c, r, w, a, b, d, clken, reset_req, reset_n);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic nop();
    op(1'b1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mknown[i] = 4'h0;
    reset_n = 1'b0; reset_req = 1'b0; clken = 1'b1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wd = '0;
    @(negedge clk);
    compare_all();
    lit("reset_rdv1", 32'(bus1.readdatavalid), 32'h0);
    lit("reset_rdv2", 32'(bus2.readdatavalid), 32'h0);
    lit("reset_rerr", 32'(bus1.rangeerr), 32'h0);
    reset_n = 1'b1;

    // Preload and full-word write/read.
    op(1, 0, 1, 0, 4'hF, 32'h0000_000A);
    op(1, 0, 1, 1, 4'hF, 32'h0000_000B);
    op(1, 0, 1, 2, 4'hF, 32'h0000_000C);
    op(1, 0, 1, 5, 4'hF, 32'hDEAD_BEEF);
    op(1, 1, 0, 5, 4'h0, 32'h0);
    lit("word_rdv1", 32'(bus1.readdatavalid), 32'h1);
    lit("word_data1", bus1.readdata, 32'hDEAD_BEEF);
    lit("word_rdv2_early", 32'(bus2.readdatavalid), 32'h0);
    nop();
    lit("word_data2", bus2.readdata, 32'hDEAD_BEEF);

    // Byte lanes, read right after the write.
    op(1, 0, 1, 5, 4'h5, 32'h1122_3344);
    op(1, 1, 0, 5, 4'h0, 32'h0);
    lit("lanes_data1", bus1.readdata, 32'hDE22_BE44);
    nop();
    lit("lanes_data2", bus2.readdata, 32'hDE22_BE44);

    // Back-to-back reads.
    op(1, 1, 0, 0, 4'h0, 32'h0);
    lit("b2b_data1_0", bus1.readdata, 32'hA);
    op(1, 1, 0, 1, 4'h0, 32'h0);
    lit("b2b_data2_0", bus2.readdata, 32'hA);
    op(1, 1, 0, 2, 4'h0, 32'h0);
    lit("b2b_data2_1", bus2.readdata, 32'hB);
    nop();
    lit("b2b_data2_2", bus2.readdata, 32'hC);
    lit("b2b_rdv2_2", 32'(bus2.readdatavalid), 32'h1);

    // Stall right after an accepted read.
    op(1, 1, 0, 5, 4'h0, 32'h0);
    clken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      op(1, 1, 0, 7, 4'h0, 32'h0);
      lit("stall_wait", 32'(bus1.waitrequest), 32'h1);
      lit("stall_rdv1_held", 32'(bus1.readdatavalid), 32'h1);
      lit("stall_rdv2_held", 32'(bus2.readdatavalid), 32'h0);
    end
    clken = 1'b1;
    nop();
    lit("stall_rdv2_out", 32'(bus2.readdatavalid), 32'h1);
    lit("stall_data2_out", bus2.readdata, 32'hDE22_BE44);

    // reset_req blocks a write.
    reset_req = 1'b1;
    op(1, 0, 1, 0, 4'hF, 32'hFFFF_FFFF);
    lit("rreq_wait", 32'(bus2.waitrequest), 32'h1);
    reset_req = 1'b0;

    // Out of range.
    op(1, 0, 1, 1000, 4'hF, 32'h5555_5555);
    lit("range_flag", 32'(bus1.rangeerr), 32'h1);
    op(1, 1, 0, 1000, 4'h0, 32'h0);
    lit("range_rdv1", 32'(bus1.readdatavalid), 32'h1);
    lit("range_data1", bus1.readdata, 32'h0);
    op(1, 1, 0, 0, 4'h0, 32'h0);
    lit("range_word0", bus1.readdata, 32'hA);

    // Reset with a read in flight.
    op(1, 1, 0, 1, 4'h0, 32'h0);
    reset_n = 1'b0;
    op(0, 0, 0, 0, 4'h0, 32'h0);
    lit("rst_rerr", 32'(bus2.rangeerr), 32'h0);
    reset_n = 1'b1;
    nop();
    lit("rst_drop2", 32'(bus2.readdatavalid), 32'h0);
    op(1, 1, 0, 1, 4'h0, 32'h0);
    nop();
    lit("rst_keep_mem", bus2.readdata, 32'hB);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int a, kind;
      reset_req = ($urandom_range(0, 19) == 0);
      clken     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        op(0, 0, 0, 0, 4'h0, 32'h0);
        reset_n = 1'b1;
      end else begin
        a    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(990, 1023))
                                           : int'($urandom_range(0, 15));
        kind = int'($urandom_range(0, 7));
        op($urandom_range(0, 9) != 0, kind inside {1, 2, 3, 7}, kind inside {4, 5, 7},
           a, 4'($urandom_range(0, 15)), $urandom());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
